// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   mult_state_e : controller state encoding (IDLE / CALC / DONE)
//   StateW       : width of the state register
//   cnt_width()  : width of the iteration down-counter for a W-bit operand
package mult_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } mult_state_e;

    // The counter has to hold W-1, which always fits in $clog2(W) bits.
    // Keep at least one bit so that W=2 still gets a real register.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Controller for seq_multiplier: three-state FSM plus the iteration down-counter.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   multiply request, only honoured in IDLE
//   load   out  combinational: operands are captured on this edge
//   calc   out  combinational: perform one add/shift iteration on this edge
//   done   out  registered one-cycle result-valid pulse
//   busy   out  registered, high through CALC and DONE
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic calc,
    output logic done,
    output logic busy
);

    localparam int unsigned PW = cnt_width(W);
    localparam logic [PW-1:0] PInit = PW'(W - 1);

    mult_state_e   state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          zbit;
    logic          done_q, busy_q;

    assign zbit = (p_q == '0);
    assign done = done_q;
    assign busy = busy_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        load    = 1'b0;
        calc    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    p_d     = PInit;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                calc = 1'b1;
                // The iteration with P==0 is the last one; hold P at zero.
                if (zbit) begin
                    state_d = StDone;
                end else begin
                    p_d = p_q - PW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // busy/done are registered copies of the next-state decode so they
    // line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            done_q  <= (state_d == StDone);
            busy_q  <= (state_d != StIdle);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// W-bit sequential shift-and-add multiplier with start/done handshake.
// One add-and-shift iteration per cycle; a result takes W+1 cycles from the
// accepting edge to done, and a new operation can start every W+2 cycles.
// Optional feature macro: MULT_SIGNED_EN adds the signed_op port and
// two's-complement operation (magnitude multiply plus final negation).
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   multiply request, sampled only while idle
//   in_a       in   multiplicand, captured on the accepted start
//   in_b       in   multiplier, captured on the accepted start
//   signed_op  in   (MULT_SIGNED_EN only) treat operands as two's complement
//   busy       out  high through the calculation and the done cycle
//   done       out  one-cycle pulse, product valid
//   product    out  2W-bit result, held until the next accepted start
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
`ifdef MULT_SIGNED_EN
    input  logic           signed_op,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [W-1:0]   a_q, b_q, q_q;
    logic           c_q;
    logic [W:0]     sum;
    logic [W-1:0]   op_a, op_b;
    logic [2*W-1:0] raw_product;
    logic           load, calc;

    mult_ctrl #(
        .W(W)
    ) u_ctrl (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .load (load),
        .calc (calc),
        .done (done),
        .busy (busy)
    );

`ifdef MULT_SIGNED_EN
    logic sign_q;

    // Multiply magnitudes; -2^(W-1) negates to itself, which is exactly its
    // magnitude when read as an unsigned W-bit value.
    always_comb begin
        op_a = in_a;
        op_b = in_b;
        if (signed_op) begin
            if (in_a[W-1]) op_a = -in_a;
            if (in_b[W-1]) op_b = -in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
        end else if (load) begin
            sign_q <= signed_op & (in_a[W-1] ^ in_b[W-1]);
        end
    end

    assign product = sign_q ? -raw_product : raw_product;
`else
    assign op_a    = in_a;
    assign op_b    = in_b;
    assign product = raw_product;
`endif

    // C is always cleared by the shift, so the sum cannot overflow W+1 bits.
    assign sum         = {c_q, a_q} + (q_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    assign raw_product = {a_q, q_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            q_q <= '0;
            c_q <= 1'b0;
        end else if (load) begin
            b_q <= op_a;
            q_q <= op_b;
            a_q <= '0;
            c_q <= 1'b0;
        end else if (calc) begin
            // Merged add and shift: {C,A,Q} <= {sum,Q} >> 1.
            {c_q, a_q, q_q} <= {sum, q_q} >> 1;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st  [NDUT];
    logic [15:0] opa [NDUT];
    logic [15:0] opb [NDUT];
    logic        sop [NDUT];
    logic        bsy [NDUT];
    logic        dn  [NDUT];
    logic [31:0] prd [NDUT];
    logic [3:0]  p2;
    logic [15:0] p8;
    logic [31:0] p16;

    int n_pass  = 0;
    int n_total = 0;
    bit armed   = 1'b0;

    // Reference model state, one slot per DUT.
    int              cnt   [NDUT];
    longint unsigned pend  [NDUT];
    longint unsigned expp  [NDUT];
    bit              valid [NDUT];

    always #5 clk = ~clk;

    assign prd[0] = {28'd0, p2};
    assign prd[1] = {16'd0, p8};
    assign prd[2] = p16;

    seq_multiplier #(.W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_a(opa[0][1:0]), .in_b(opb[0][1:0]),
`ifdef MULT_SIGNED_EN
        .signed_op(sop[0]),
`endif
        .busy(bsy[0]), .done(dn[0]), .product(p2)
    );

    seq_multiplier #(.W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_a(opa[1][7:0]), .in_b(opb[1][7:0]),
`ifdef MULT_SIGNED_EN
        .signed_op(sop[1]),
`endif
        .busy(bsy[1]), .done(dn[1]), .product(p8)
    );

    seq_multiplier #(.W(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_a(opa[2]), .in_b(opb[2]),
`ifdef MULT_SIGNED_EN
        .signed_op(sop[2]),
`endif
        .busy(bsy[2]), .done(dn[2]), .product(p16)
    );

    function automatic int unsigned wof(input int i);
        case (i)
            0:       return 2;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic bit sgn_of(input int i);
`ifdef MULT_SIGNED_EN
        return sop[i];
`else
        return 1'b0;
`endif
    endfunction

    // Plain arithmetic product of two w-bit operands, 2w-bit result.
    function automatic longint unsigned exp_mul(input longint unsigned a, input longint unsigned b,
                                                input int unsigned w, input bit sg);
        longint unsigned m  = (64'd1 << w) - 1;
        longint unsigned m2 = (64'd1 << (2 * w)) - 1;
        longint          sa;
        longint          sb;
        a  = a & m;
        b  = b & m;
        sa = longint'(a);
        sb = longint'(b);
        if (sg) begin
            if (((a >> (w - 1)) & 1) != 0) sa = sa - longint'(64'd1 << w);
            if (((b >> (w - 1)) & 1) != 0) sb = sb - longint'(64'd1 << w);
        end
        return 64'(sa * sb) & m2;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    endtask

    // Model: an accepted start makes the unit busy for W+1 cycles; done in the
    // last of them, with the arithmetic product from then on.
    always @(posedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                cnt[i]   = 0;
                valid[i] = 1'b1;
                expp[i]  = 0;
            end else if (cnt[i] == 0) begin
                if (st[i]) begin
                    cnt[i]   = int'(wof(i)) + 1;
                    valid[i] = 1'b0;
                    pend[i]  = exp_mul(opa[i], opb[i], wof(i), sgn_of(i));
                end
            end else begin
                cnt[i] = cnt[i] - 1;
                if (cnt[i] == 1) begin
                    valid[i] = 1'b1;
                    expp[i]  = pend[i];
                end
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < NDUT; i++) begin
                chk($sformatf("w%0d_busy", wof(i)), bsy[i], cnt[i] > 0);
                chk($sformatf("w%0d_done", wof(i)), dn[i], cnt[i] == 1);
                if (valid[i]) chk($sformatf("w%0d_product", wof(i)), prd[i], expp[i]);
            end
        end
    end

    // Single op on the W=8 unit; measures latency and busy length.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sg,
                       output int lat, output int bc, output logic [15:0] pr);
        @(negedge clk);
        st[1] = 1'b1; opa[1] = {8'd0, a}; opb[1] = {8'd0, b}; sop[1] = sg;
        @(negedge clk);
        st[1] = 1'b0;
        lat = 0; bc = 0; pr = '0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (bsy[1]) bc++;
            if (dn[1]) begin
                lat = n;
                pr  = prd[1][15:0];
                break;
            end
        end
    endtask

    task automatic rand_ops(input int i, input int nops);
        int unsigned w = wof(i);
        for (int k = 0; k < nops; k++) begin
            @(negedge clk);
            st[i]  = 1'b1;
            opa[i] = 16'($urandom);
            opb[i] = 16'($urandom);
            sop[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) opa[i] = 16'(1) << (w - 1);
            if ($urandom_range(0, 7) == 0) opb[i] = 16'(1) << (w - 1);
            // Stray requests while busy must be ignored.
            for (int j = 0; j < int'(w); j++) begin
                @(negedge clk);
                st[i]  = 1'($urandom_range(0, 1));
                opa[i] = 16'($urandom);
                opb[i] = 16'($urandom);
            end
            @(negedge clk);
            st[i] = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, bc, nd, t1, t2;
        logic [15:0] pr, r1, r2;
        for (int i = 0; i < NDUT; i++) begin
            st[i] = 1'b0; opa[i] = '0; opb[i] = '0; sop[i] = 1'b0;
        end

        // Pin the model with hand-computed values.
        chk("model_13x11", exp_mul(13, 11, 8, 1'b0), 143);
        chk("model_255x255", exp_mul(255, 255, 8, 1'b0), 16'hFE01);
        chk("model_s_m3x5", exp_mul(8'hFD, 5, 8, 1'b1), 16'hFFF1);
        chk("model_s_m128x127", exp_mul(8'h80, 8'h7F, 8, 1'b1), 16'hC080);

        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset_busy", bsy[1], 0);
        chk("reset_done", dn[1], 0);
        chk("reset_product", prd[1], 0);
        rst_n = 1'b1;

        op8(8'd13, 8'd11, 1'b0, lat, bc, pr);
        chk("13x11_latency", lat, 9);
        chk("13x11_busy_len", bc, 9);
        chk("13x11_product", pr, 143);

        op8(8'd255, 8'd255, 1'b0, lat, bc, pr);
        chk("255x255_product", pr, 65025);
        op8(8'd0, 8'd200, 1'b0, lat, bc, pr);
        chk("0x200_latency", lat, 9);
        chk("0x200_product", pr, 0);

        // start held high: 7x9 then 3x3, done pulses W+2 apart.
        @(negedge clk);
        st[1] = 1'b1; opa[1] = 16'd7; opb[1] = 16'd9; sop[1] = 1'b0;
        @(negedge clk);
        opa[1] = 16'd3; opb[1] = 16'd3;
        nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (dn[1]) begin
                nd++;
                if (nd == 1) begin t1 = n; r1 = prd[1][15:0]; end
                else begin t2 = n; r2 = prd[1][15:0]; st[1] = 1'b0; break; end
            end
        end
        st[1] = 1'b0;
        chk("held_done_count", nd, 2);
        chk("held_first", r1, 63);
        chk("held_second", r2, 9);
        chk("held_spacing", t2 - t1, 10);

        // Reset during CALC cycle 4 aborts the operation.
        repeat (2) @(negedge clk);
        st[1] = 1'b1; opa[1] = 16'd100; opb[1] = 16'd77;
        @(negedge clk);
        st[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", bsy[1], 0);
        chk("abort_product", prd[1], 0);
        chk("abort_done", dn[1], 0);
        rst_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[1]) nd++;
        end
        chk("abort_no_done", nd, 0);
        op8(8'd5, 8'd6, 1'b0, lat, bc, pr);
        chk("after_abort_5x6", pr, 30);

`ifdef MULT_SIGNED_EN
        op8(8'hFD, 8'd5, 1'b1, lat, bc, pr);
        chk("s_m3x5", pr, 16'hFFF1);
        chk("s_latency", lat, 9);
        op8(8'h80, 8'h80, 1'b1, lat, bc, pr);
        chk("s_m128xm128", pr, 16384);
        op8(8'h80, 8'h7F, 1'b1, lat, bc, pr);
        chk("s_m128x127", pr, 16'hC080);
`endif

        fork
            rand_ops(0, 1000);
            rand_ops(1, 400);
            rand_ops(2, 1000);
        join
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier with an integrated controller and a start/done handshake. It is the W-bit successor to the 3-bit multiplier datapath and controller pair: add and shift are merged into one cycle, and an optional signed mode is available. It sits between operand-producing logic (switch/register front end) and product consumers (display or downstream arithmetic).

## Interface
Parameters:
- `W`, 8, operand width in bits; legal range is 2 and above.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `in_a`  in  W  multiplicand; captured on the accepted `start`.
- `in_b`  in  W  multiplier; captured on the accepted `start`.
- `signed_op`  in  1  two's-complement operation; present only with `MULT_SIGNED_EN`.
- `busy`  out  1  high from the cycle after an accepted start until `done` deasserts.
- `done`  out  1  one-cycle pulse; product valid.
- `product`  out  2W  result; held until the next accepted start.

## Operation
- Registers:
  - `A` (W bits), `B` (W bits), `Q` (W bits), carry `C`.
  - Down-counter `P`, $clog2(W) bits.
  - `state`.
- FSM states are IDLE, CALC and DONE.
- IDLE, with `start` high:
  - Load `B`=`in_a`, `Q`=`in_b`, `A`=0, `C`=0, `P`=W-1.
  - Go to CALC.
- CALC, every cycle:
  - Compute sum = A + (Q[0] ? B : 0), W+1 bits (carry plus W).
  - Update {C,A,Q} <= {sum,Q} >> 1, so C becomes 0.
  - `P` decrements.
  - When `P`==0, perform the final iteration and go to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Unconditionally return to IDLE.
- `product` = {A,Q}. No overflow is possible: W×W fits in 2W bits.
- `start` while not in IDLE, including the DONE cycle, is ignored. It is not queued.
- `start` is level-sampled: if it is held high in IDLE, a new operation begins every W+2 cycles.
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - `A`, `B`, `Q`, `C`, `P` and the sign flag go to 0.
  - `busy`=0, `done`=0, `product`=0.
  - Reset mid-operation aborts it; no `done` is produced.

## Timing
- Start accepted at edge 0.
- CALC occupies the cycles after edges 0 through W-1, W cycles in total.
- `done` is high in the cycle after edge W: latency is W+1 cycles from the accepting edge to `done`.
- Throughput is one result per W+2 cycles.
- `busy` is high for W+1 cycles, covering CALC and DONE.
- `product` changes during CALC and is valid only with `done` and afterwards.
- All outputs are registered, except the optional negation (see Configuration), which is combinational on `product`.

## Configuration
- `MULT_SIGNED_EN` defined:
  - `signed_op` port exists.
  - When `signed_op`=1 at the accepted start:
    - `B` loads |`in_a|` and `Q` loads |`in_b|`.
    - A sign register stores `in_a`[W-1] ^ `in_b`[W-1].
    - `product` = sign ? −{A,Q} : {A,Q}, in 2W-bit two's complement.
  - Special operand −2^(W-1): its magnitude 2^(W-1) fits in W unsigned bits.
  - The product (−2^(W-1))² = 2^(2W-2) is representable.
  - Latency is unchanged.
  - With `signed_op`=0, behaviour is identical to an unsigned build.
- Macro undefined:
  - No `signed_op` port and no sign register.
  - Operands are always unsigned.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum (IDLE/CALC/DONE);
  - a 2-bit state-width constant;
  - a `clog2`-based counter-width helper.
- One sub-module, `mult_ctrl`, is the natural split:
  - It contains the FSM and down-counter.
  - It emits `load`, `calc`, `done` and `busy`, and takes `Zbit`=(`P`==0).
- The top level holds the datapath registers and the merged add/shift.

## Test plan
- W=8, `in_a`=13, `in_b`=11, `start` pulse:
  - `done` 9 cycles after the accepting edge;
  - `product`=143;
  - `busy` high for 9 cycles.
- W=8, 255×255 → `product`=65025 (0xFE01). Then 0×200 → `product`=0 with the same latency.
- `start` held high continuously, with operands 7×9 then 3×3:
  - results 63 and 9;
  - `done` pulses 10 cycles apart;
  - mid-operation `start` edges ignored.
- `rst_n` low at CALC cycle 4 → next cycle `busy`=0, `product`=0, no `done`. A fresh 5×6 afterwards → 30.
- `MULT_SIGNED_EN`, `signed_op`=1, W=8:
  - −3×5 → 0xFFF1;
  - −128×−128 → 16384;
  - −128×127 → −16256 (0xC080).
- W=2 and W=16 sweeps against a reference model, random operands, 1000 ops each → zero mismatches.
